pixel_scan_fifo: RTL

Pixel source stage sitting directly upstream of the ILI9341 SPI driver. It walks the panel raster in panel write order, presents the current coordinate to a combinational shader, and captures the returned colour into a small show-ahead FIFO. The TFT driver drains the FIFO with a valid/ready handshake, which decouples shader timing from SPI byte timing. A one-cycle frame_done pulse marks each completed frame for game-physics ticking.

---
 rtl/pixel_scan_fifo.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pixel_scan_fifo.sv
// Raster scanner feeding a shader-coloured pixel stream into a small show-ahead FIFO
// for the ILI9341 SPI driver; walks columns outer, rows inner (panel write order).
module pixel_scan_fifo #(
  parameter int unsigned WIDTH   = 320,
  parameter int unsigned HEIGHT  = 240,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned COLOR_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         restart,
  output logic [8:0]                   coord_x,
  output logic [7:0]                   coord_y,
  input  logic [COLOR_W-1:0]           color_in,
  output logic [COLOR_W-1:0]           pix_data,
  output logic                         pix_sof,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [$clog2(DEPTH):0]       fill_level,
  output logic                         frame_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned XW = 9;
  localparam int unsigned YW = 8;

  typedef struct packed {
    logic               sof;
    logic [COLOR_W-1:0] color;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            pop_c;
  logic            push_c;
  logic            full_c;
  logic            last_x_c;
  logic            last_y_c;
  logic [XW-1:0]   next_x_c;
  logic [YW-1:0]   next_y_c;
  entry_t          wdata_c;
  entry_t          head_c;

  // Handshake and capture qualification; restart overrides both directions.
  always_comb begin
    full_c   = (fill_level == CW'(DEPTH));
    pop_c    = pix_valid & pix_ready & ~restart;
    push_c   = enable & ~restart & (~full_c | (pix_valid & pix_ready));
    last_x_c = (coord_x == XW'(WIDTH - 1));
    last_y_c = (coord_y == YW'(HEIGHT - 1));
  end

  // Next scan position: row counter wraps into the column counter.
  always_comb begin
    next_x_c = coord_x;
    next_y_c = coord_y + YW'(1);
    if (last_y_c) begin
      next_y_c = '0;
      next_x_c = last_x_c ? '0 : coord_x + XW'(1);
    end
  end

  always_comb begin
    wdata_c.sof   = (coord_x == '0) && (coord_y == '0);
    wdata_c.color = color_in;
  end

  // Scan position and frame-complete pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coord_x    <= '0;
      coord_y    <= '0;
      frame_done <= 1'b0;
    end else if (restart) begin
      coord_x    <= '0;
      coord_y    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= push_c & last_x_c & last_y_c;
      if (push_c) begin
        coord_x <= next_x_c;
        coord_y <= next_y_c;
      end
    end
  end

  // FIFO pointers and occupancy; the count disambiguates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else if (restart) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      if (push_c && !pop_c)      fill_level <= fill_level + CW'(1);
      else if (pop_c && !push_c) fill_level <= fill_level - CW'(1);
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wdata_c;
  end

  // Show-ahead head; forced to zero while empty so stale entries never leak out.
  always_comb begin
    head_c    = mem[rd_ptr];
    pix_valid = (fill_level != '0);
    pix_data  = pix_valid ? head_c.color : '0;
    pix_sof   = pix_valid & head_c.sof;
  end

endmodule
